tag_lookup_sequencer: RTL

Set-associative tag lookup and allocation controller for the L2 cache model. It owns the per-set tag/valid array and time-shares a single 5-bit tag equality compare across all ways, walking one way per cycle. Requests and responses use valid/ready handshakes, and a round-robin victim pointer per set chooses the way to replace on a miss with allocate. It sits between the L2 request front end and the data-array controller, which consumes the hit/way/evict result.

---
 rtl/tag_lookup_sequencer.sv | 133 +++++++++++++
 1 files changed

// File: rtl/tag_lookup_sequencer.sv
// tag_lookup_sequencer: set-associative tag lookup/allocate controller that walks one way per cycle
module tag_lookup_sequencer #(
  parameter int TAG_W = 5,
  parameter int WAYS = 4,
  parameter int IDX_W = 3,
  localparam int WAY_W = $clog2(WAYS),
  localparam int SETS = 1 << IDX_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [TAG_W-1:0] req_tag,
  input  logic [IDX_W-1:0] req_index,
  input  logic             req_alloc,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_hit,
  output logic [WAY_W-1:0] resp_way,
  output logic             resp_evict,
  input  logic             flush,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, COMPARE, RESP} state_t;
  state_t state_q, state_d;
  logic [WAY_W-1:0] ptr_q, ptr_d;
  logic [TAG_W-1:0] lat_tag_q, lat_tag_d;
  logic [IDX_W-1:0] lat_idx_q, lat_idx_d;
  logic lat_alloc_q, lat_alloc_d;
  logic resp_valid_q, resp_valid_d, resp_hit_q, resp_hit_d, resp_evict_q, resp_evict_d;
  logic [WAY_W-1:0] resp_way_q, resp_way_d;
  logic [SETS-1:0][WAYS-1:0] valid_q, valid_d;
  logic [SETS-1:0][WAY_W-1:0] rr_q, rr_d;
  logic [TAG_W-1:0] tag_q [SETS][WAYS];
  logic has_inv, match, wr_en;
  logic [WAY_W-1:0] inv_way, victim;
  assign req_ready = (state_q == IDLE) && !flush;
  assign busy = state_q != IDLE;
  assign resp_valid = resp_valid_q;
  assign resp_hit = resp_hit_q;
  assign resp_way = resp_way_q;
  assign resp_evict = resp_evict_q;
  // Victim prefers the lowest invalid way so the round-robin pointer only ages on true evictions
  always_comb begin
    has_inv = 1'b0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid_q[lat_idx_q][w]) begin
        has_inv = 1'b1;
        inv_way = WAY_W'(w);
      end
    victim = has_inv ? inv_way : rr_q[lat_idx_q];
    match = valid_q[lat_idx_q][ptr_q] && (tag_q[lat_idx_q][ptr_q] == lat_tag_q);
    state_d = state_q;
    ptr_d = ptr_q;
    lat_tag_d = lat_tag_q;
    lat_idx_d = lat_idx_q;
    lat_alloc_d = lat_alloc_q;
    resp_valid_d = resp_valid_q;
    resp_hit_d = resp_hit_q;
    resp_way_d = resp_way_q;
    resp_evict_d = resp_evict_q;
    valid_d = valid_q;
    rr_d = rr_q;
    wr_en = 1'b0;
    case (state_q)
      IDLE:
        if (flush) valid_d = '0;
        else if (req_valid) begin
          lat_tag_d = req_tag;
          lat_idx_d = req_index;
          lat_alloc_d = req_alloc;
          ptr_d = '0;
          state_d = COMPARE;
        end
      COMPARE:
        if (match) begin
          resp_hit_d = 1'b1;
          resp_way_d = ptr_q;
          resp_evict_d = 1'b0;
          resp_valid_d = 1'b1;
          state_d = RESP;
        end else if (ptr_q != WAY_W'(WAYS - 1)) ptr_d = ptr_q + 1'b1;
        else begin
          resp_hit_d = 1'b0;
          resp_way_d = lat_alloc_q ? victim : '0;
          resp_evict_d = lat_alloc_q && valid_q[lat_idx_q][victim];
          resp_valid_d = 1'b1;
          state_d = RESP;
          if (lat_alloc_q) begin
            wr_en = 1'b1;
            valid_d[lat_idx_q][victim] = 1'b1;
            if (!has_inv) rr_d[lat_idx_q] = rr_q[lat_idx_q] + 1'b1;
          end
        end
      RESP:
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d = IDLE;
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q <= '0;
      lat_tag_q <= '0;
      lat_idx_q <= '0;
      lat_alloc_q <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_hit_q <= 1'b0;
      resp_way_q <= '0;
      resp_evict_q <= 1'b0;
      valid_q <= '0;
      rr_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      lat_tag_q <= lat_tag_d;
      lat_idx_q <= lat_idx_d;
      lat_alloc_q <= lat_alloc_d;
      resp_valid_q <= resp_valid_d;
      resp_hit_q <= resp_hit_d;
      resp_way_q <= resp_way_d;
      resp_evict_q <= resp_evict_d;
      valid_q <= valid_d;
      rr_q <= rr_d;
    end
  // Tag contents need no reset; the valid bits gate every compare
  always_ff @(posedge clk)
    if (wr_en) tag_q[lat_idx_q][victim] <= lat_tag_q;
endmodule
